seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
Receive-side counterpart of the 4-digit multiplexed 7-segment display driver. It samples the scanned AN/SEGMENT bus, waits for each digit to settle, and decodes the segment pattern back to a hex nibble. Once all four digits have been seen, it assembles and presents the 16-bit value. It serves as a self-check and loopback monitor for the scoreboard display path, and as an observer for game-logic verification.

Parameters:
SETTLE, 16, consecutive cycles AN/SEGMENT must be unchanged (after synchronisation) before a digit is decoded
TIMEOUT_W, 20, width of the frame-timeout counter; stale asserts after 2^TIMEOUT_W-1 cycles without a complete frame

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
AN  in  4  anode enables, active-low; AN[0] = rightmost digit = num[3:0], AN[3] = num[15:12]
SEGMENT  in  8  segment lines, active-low; [0]=a .. [6]=g, [7]=dp
num  out  16  last fully decoded value
dp  out  4  decimal-point state per digit (1 = lit), same index as AN
valid  out  1  one-cycle pulse when num/dp update
pattern_err  out  1  set with valid if any digit of that frame had an undecodable pattern
stale  out  1  high while no complete frame has arrived within the timeout window

Behaviour:
- Reset: interface is synchronous, active-low, one clock (clk); rst_n sampled on the clk rising edge only. While rst_n=0 and the cycle after: num=0, dp=0, valid=0, pattern_err=0, stale=0. Clears sync flops, settle counter, seen[3:0], frame error flag, timeout counter; FSM -> SETTLING. Mid-frame reset discards partial frame, no valid.
- Input path: 2-flop synchroniser on {AN,SEGMENT}; all logic uses synchronised copy s_an/s_seg.
- FSM SETTLING: cnt increments each cycle s_an/s_seg equal previous cycle; any change -> cnt=0. When cnt reaches SETTLE-1 and s_an has exactly one bit low -> decode, go HOLD. If s_an not one-hot-low (blank 4'hF or multiple low) -> stay SETTLING, nothing captured.
- FSM HOLD: no further decode; any change of s_an or s_seg -> cnt=0, SETTLING. Each stable window decodes at most once.
- Decode (active-high gfedcba = ~s_seg[6:0]): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->b, 39->C, 5E->d, 79->E, 71->F. Other pattern -> nibble 0, frame error flag set. dp bit = ~s_seg[7].
- Capture: nibble/dp written to shadow slot k (k = index of low AN bit), seen[k]=1. Re-capturing an already-seen digit overwrites the slot.
- Frame completion: on the cycle after seen becomes 4'hF: num<=shadow, dp<=shadow dp, pattern_err<=frame flag, valid=1 for exactly one cycle. seen, frame flag cleared the same cycle. Timeout counter cleared, stale<=0.
- Latency: last digit's inputs stable at pins -> valid after 2 (sync) + SETTLE + 2 cycles.
- Timeout: counter increments every cycle without a completed frame, saturating at all-ones. stale=1 while saturated; it clears only on the next valid.
- num/dp/pattern_err hold between valid pulses.
- Simultaneous: a completion and a new capture in the same cycle — the capture lands in the fresh (cleared) seen/shadow and belongs to the next frame.

Test Plan:
- Reset: rst_n=0 for 3 cycles with bus toggling -> num=0, dp=0, valid=0, stale=0; no valid within 100 cycles after release if AN=4'hF.
- Clean scan of 16'h1A2F: AN 1110/1101/1011/0111, SEGMENT 8E/A4/88/F9, each held 40 cycles -> exactly one valid; num=16'h1A2F, dp=0, pattern_err=0; valid 20 cycles after the 4th digit starts (SETTLE=16).
- Glitch: digit held for only 10 cycles, then correct value -> only the stable value is captured; no valid until all 4 are stable; num correct.
- Bad pattern: digit 2 SEGMENT=8'hFE (only a lit), others valid for 16'h0000 -> valid, num=16'h0000, pattern_err=1; next clean frame -> pattern_err=0.
- Decimal point plus ghosting: digit 0 SEGMENT=8'h40 ('0' with dp); AN=4'b1100 for 50 cycles inserted -> dp=4'b0001; the multi-anode interval is never captured.
- Timeout: TIMEOUT_W=8, AN=4'hF forever -> stale=1 at cycle 255; one clean frame -> stale=0 with valid; mid-frame rst_n pulse -> partial frame discarded, no valid.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - observer that decodes a scanned 4-digit 7-segment bus back to a 16-bit value
module seg_scan_decoder #(
  parameter int SETTLE    = 16,
  parameter int TIMEOUT_W = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  AN,
  input  logic [7:0]  SEGMENT,
  output logic [15:0] num,
  output logic [3:0]  dp,
  output logic        valid,
  output logic        pattern_err,
  output logic        stale
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_MAX = {TIMEOUT_W{1'b1}};

  typedef enum logic {ST_SETTLING, ST_HOLD} state_e;

  logic [3:0]           an_m_q, s_an_q, p_an_q;
  logic [7:0]           seg_m_q, s_seg_q, p_seg_q;
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           seen_q, seen_d;
  logic                 ferr_q, ferr_d;
  logic [15:0]          shadow_q, shadow_d;
  logic [3:0]           shadow_dp_q, shadow_dp_d;
  logic [15:0]          num_q;
  logic [3:0]           dp_q;
  logic                 valid_q, perr_q;
  logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;

  logic       changed, one_low, capture, complete;
  logic [3:0] an_low;
  logic [1:0] idx;
  logic [4:0] dec;

  // Returns {bad, nibble}; input is the active-high gfedcba pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] lit);
    logic [4:0] r;
    r = 5'h10;
    case (lit)
      7'h3F: r = 5'h00;
      7'h06: r = 5'h01;
      7'h5B: r = 5'h02;
      7'h4F: r = 5'h03;
      7'h66: r = 5'h04;
      7'h6D: r = 5'h05;
      7'h7D: r = 5'h06;
      7'h07: r = 5'h07;
      7'h7F: r = 5'h08;
      7'h6F: r = 5'h09;
      7'h77: r = 5'h0A;
      7'h7C: r = 5'h0B;
      7'h39: r = 5'h0C;
      7'h5E: r = 5'h0D;
      7'h79: r = 5'h0E;
      7'h71: r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  always_comb begin
    an_low  = ~s_an_q;
    changed = (s_an_q != p_an_q) || (s_seg_q != p_seg_q);
    one_low = (an_low != 4'h0) && ((an_low & (an_low - 4'h1)) == 4'h0);
    dec     = decode_seg(~s_seg_q[6:0]);
    case (an_low)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_SETTLING: begin
        if (changed) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          // A blank or ghosted anode pattern parks here until the bus moves.
          if (one_low) begin
            capture = 1'b1;
            state_d = ST_HOLD;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HOLD: begin
        if (changed) begin
          cnt_d   = '0;
          state_d = ST_SETTLING;
        end
      end
      default: state_d = ST_SETTLING;
    endcase
  end

  always_comb begin
    complete    = (seen_q == 4'hF);
    seen_d      = complete ? 4'h0 : seen_q;
    ferr_d      = complete ? 1'b0 : ferr_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    // A capture coinciding with completion starts the next frame.
    if (capture) begin
      seen_d[idx]              = 1'b1;
      ferr_d                   = ferr_d | dec[4];
      shadow_d[{idx, 2'b00} +: 4] = dec[3:0];
      shadow_dp_d[idx]         = ~s_seg_q[7];
    end
    if (complete)
      tcnt_d = '0;
    else if (tcnt_q == TMO_MAX)
      tcnt_d = tcnt_q;
    else
      tcnt_d = tcnt_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_m_q      <= '0;
      seg_m_q     <= '0;
      s_an_q      <= '0;
      s_seg_q     <= '0;
      p_an_q      <= '0;
      p_seg_q     <= '0;
      state_q     <= ST_SETTLING;
      cnt_q       <= '0;
      seen_q      <= '0;
      ferr_q      <= 1'b0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      num_q       <= '0;
      dp_q        <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      an_m_q      <= AN;
      seg_m_q     <= SEGMENT;
      s_an_q      <= an_m_q;
      s_seg_q     <= seg_m_q;
      p_an_q      <= s_an_q;
      p_seg_q     <= s_seg_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      ferr_q      <= ferr_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      valid_q     <= complete;
      tcnt_q      <= tcnt_d;
      if (complete) begin
        num_q  <= shadow_q;
        dp_q   <= shadow_dp_q;
        perr_q <= ferr_q;
      end
    end
  end

  assign num         = num_q;
  assign dp          = dp_q;
  assign valid       = valid_q;
  assign pattern_err = perr_q;
  assign stale       = (tcnt_q == TMO_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - bench for seg_scan_decoder with a run-level reference model
module tb_seg_scan_decoder;

  localparam int SETTLE = 16;
  localparam int TW     = 8;
  localparam int MAXE   = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [15:0] num;
  logic [3:0]  dp;
  logic        valid, pattern_err, stale;

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .AN(an), .SEGMENT(seg),
    .num(num), .dp(dp), .valid(valid), .pattern_err(pattern_err), .stale(stale)
  );

  int errors = 0;
  int checks = 0;
  int n_e;

  logic [3:0]  pin_an  [MAXE];
  logic [7:0]  pin_seg [MAXE];
  bit          e_v [MAXE];
  logic [15:0] e_num [MAXE];
  logic [3:0]  e_dp [MAXE];
  bit          e_perr [MAXE];
  bit          e_st [MAXE];
  bit          a_v [MAXE];
  logic [15:0] a_num [MAXE];
  logic [3:0]  a_dp [MAXE];
  bit          a_perr [MAXE];
  bit          a_st [MAXE];
  bit          vmark [MAXE];
  logic [15:0] vnum [MAXE];
  logic [3:0]  vdp [MAXE];
  bit          vperr [MAXE];
  int          cap_e [MAXE];
  logic [3:0]  cap_an [MAXE];
  logic [7:0]  cap_seg [MAXE];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] hex_pat(input int v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] enc(input int v, input bit lit_dp);
    return {~lit_dp, ~hex_pat(v)};
  endfunction

  task automatic add(input logic [3:0] a, input logic [7:0] s, input int dur);
    for (int i = 0; i < dur; i++) begin
      n_e++;
      pin_an[n_e]  = a;
      pin_seg[n_e] = s;
    end
  endtask

  // Runs of identical pin samples; a one-hot-low run of SETTLE+1 samples is
  // decoded SETTLE+2 edges after its first sample, valid follows one edge later.
  task automatic build_model(input int n);
    int a, b, ncap, k, nib, last_v;
    bit bad;
    logic [3:0] seen, cdp, shdp;
    logic [15:0] shn, cnum;
    bit ferr, cperr;
    logic [6:0] pat;
    for (int e = 0; e < MAXE; e++) vmark[e] = 0;
    ncap = 0;
    a = 1;
    while (a <= n) begin
      b = a;
      while (b < n && pin_an[b+1] == pin_an[a] && pin_seg[b+1] == pin_seg[a]) b++;
      if ((b - a + 1) >= SETTLE + 1 && $countones(~pin_an[a]) == 1) begin
        cap_e[ncap] = a + SETTLE + 2;
        cap_an[ncap] = pin_an[a];
        cap_seg[ncap] = pin_seg[a];
        ncap++;
      end
      a = b + 1;
    end
    seen = 0; ferr = 0; shn = 0; shdp = 0;
    for (int i = 0; i < ncap; i++) begin
      k = 0;
      for (int j = 0; j < 4; j++) if (!cap_an[i][j]) k = j;
      pat = ~cap_seg[i][6:0];
      bad = 1; nib = 0;
      for (int v = 0; v < 16; v++) if (hex_pat(v) == pat) begin bad = 0; nib = v; end
      shn[k*4 +: 4] = 4'(nib);
      shdp[k] = ~cap_seg[i][7];
      seen[k] = 1'b1;
      ferr = ferr | bad;
      if (seen == 4'hF) begin
        if (cap_e[i] + 1 <= n) begin
          vmark[cap_e[i]+1] = 1;
          vnum[cap_e[i]+1]  = shn;
          vdp[cap_e[i]+1]   = shdp;
          vperr[cap_e[i]+1] = ferr;
        end
        seen = 0;
        ferr = 0;
      end
    end
    cnum = 0; cdp = 0; cperr = 0; last_v = 0;
    for (int e = 1; e <= n; e++) begin
      if (vmark[e]) begin
        cnum = vnum[e]; cdp = vdp[e]; cperr = vperr[e]; last_v = e;
      end
      e_v[e] = vmark[e];
      e_num[e] = cnum;
      e_dp[e] = cdp;
      e_perr[e] = cperr;
      e_st[e] = (e - last_v) >= ((1 << TW) - 1);
    end
  endtask

  task automatic run_stream(input string tag, input int n);
    build_model(n);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      an = 4'($urandom);
      seg = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk({tag, " reset_outputs"}, {valid, num, dp, pattern_err, stale}, 32'h0);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= n; e++) begin
      an = pin_an[e];
      seg = pin_seg[e];
      @(posedge clk);
      @(negedge clk);
      a_v[e] = valid; a_num[e] = num; a_dp[e] = dp; a_perr[e] = pattern_err; a_st[e] = stale;
      chk($sformatf("%s cycle %0d {valid,num,dp,perr,stale}", tag, e),
          {valid, num, dp, pattern_err, stale},
          {e_v[e], e_num[e], e_dp[e], e_perr[e], e_st[e]});
    end
  endtask

  function automatic int nvalid(input int n);
    int c = 0;
    for (int e = 1; e <= n; e++) if (a_v[e]) c++;
    return c;
  endfunction

  task automatic frame_1a2f();
    add(4'b1110, 8'h8E, 40);
    add(4'b1101, 8'hA4, 40);
    add(4'b1011, 8'h88, 40);
    add(4'b0111, 8'hF9, 40);
  endtask

  task automatic gen_random(input int target);
    logic [3:0] a;
    logic [7:0] s;
    int r, dur;
    while (n_e < target) begin
      r = $urandom_range(0, 99);
      a = ~(4'b0001 << $urandom_range(0, 3));
      if (r < 70) s = enc($urandom_range(0, 15), 1'($urandom_range(0, 1)));
      else s = 8'($urandom);
      if (r >= 80 && r < 90) a = 4'hF;
      if (r >= 90) begin
        case ($urandom_range(0, 5))
          0: a = 4'b1100; 1: a = 4'b0011; 2: a = 4'b1010;
          3: a = 4'b0101; 4: a = 4'b0110; default: a = 4'b1001;
        endcase
      end
      case ($urandom_range(0, 8))
        0: dur = 3;  1: dur = 10; 2: dur = 15; 3: dur = 16; 4: dur = 17;
        5: dur = 18; 6: dur = 24; 7: dur = 40; default: dur = 60;
      endcase
      if (n_e > 0 && a == pin_an[n_e] && s == pin_seg[n_e]) s = s ^ 8'h80;
      add(a, s, dur);
    end
  endtask

  initial begin
    int vc;
    rst_n = 1'b0;
    an = 4'hF;
    seg = 8'hFF;

    n_e = 0;
    add(4'hF, 8'hFF, 100);
    run_stream("idle", n_e);
    chk("idle no valid", nvalid(n_e), 0);
    chk("idle num", a_num[100], 16'h0);

    n_e = 0;
    frame_1a2f();
    add(4'hF, 8'hFF, 30);
    run_stream("clean", n_e);
    chk("clean valid count", nvalid(n_e), 1);
    chk("clean valid at edge 140", a_v[140], 1);
    chk("clean num", a_num[140], 16'h1A2F);
    chk("clean dp", a_dp[140], 4'h0);
    chk("clean perr", a_perr[140], 0);

    n_e = 0;
    add(4'b1110, 8'h8E, 40);
    add(4'b1101, enc(7, 0), 10);
    add(4'b1101, 8'hA4, 40);
    add(4'b1011, 8'h88, 40);
    add(4'b0111, 8'hF9, 40);
    add(4'hF, 8'hFF, 20);
    run_stream("glitch", n_e);
    chk("glitch valid count", nvalid(n_e), 1);
    chk("glitch valid at edge 150", a_v[150], 1);
    chk("glitch num", a_num[n_e], 16'h1A2F);

    n_e = 0;
    add(4'b1110, 8'hC0, 40);
    add(4'b1101, 8'hC0, 40);
    add(4'b1011, 8'hFE, 40);
    add(4'b0111, 8'hC0, 40);
    add(4'b1110, 8'hC0, 40);
    add(4'b1101, 8'hC0, 40);
    add(4'b1011, 8'hC0, 40);
    add(4'b0111, 8'hC0, 40);
    add(4'hF, 8'hFF, 20);
    run_stream("badpat", n_e);
    chk("badpat valid 1", a_v[140], 1);
    chk("badpat num", a_num[140], 16'h0);
    chk("badpat perr set", a_perr[140], 1);
    chk("badpat valid 2", a_v[300], 1);
    chk("badpat perr cleared", a_perr[300], 0);

    n_e = 0;
    add(4'b1110, 8'h40, 40);
    add(4'b1100, 8'hC0, 50);
    add(4'b1101, 8'hC0, 40);
    add(4'b1011, 8'hC0, 40);
    add(4'b0111, 8'hC0, 40);
    add(4'hF, 8'hFF, 20);
    run_stream("ghost", n_e);
    chk("ghost valid count", nvalid(n_e), 1);
    chk("ghost valid at edge 190", a_v[190], 1);
    chk("ghost dp", a_dp[190], 4'b0001);
    chk("ghost num", a_num[190], 16'h0);

    n_e = 0;
    add(4'hF, 8'hFF, 300);
    frame_1a2f();
    add(4'hF, 8'hFF, 10);
    run_stream("timeout", n_e);
    chk("stale low at 254", a_st[254], 0);
    chk("stale high at 255", a_st[255], 1);
    chk("stale high at 439", a_st[439], 1);
    chk("valid at 440", a_v[440], 1);
    chk("stale cleared at 440", a_st[440], 0);

    n_e = 0;
    gen_random(3000);
    run_stream("random", n_e);

    n_e = 0;
    add(4'b1110, 8'h8E, 40);
    add(4'b1101, 8'hA4, 40);
    add(4'b1011, 8'h88, 40);
    run_stream("partial", n_e);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset outputs", {valid, num, dp, pattern_err, stale}, 32'h0);
    rst_n = 1'b1;
    vc = 0;
    an = 4'b0111;
    seg = 8'hF9;
    for (int i = 0; i < 140; i++) begin
      if (i == 40) begin
        an = 4'hF;
        seg = 8'hFF;
      end
      @(posedge clk);
      @(negedge clk);
      if (valid) vc++;
    end
    chk("midreset no valid", vc, 0);
    chk("midreset num", num, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
